prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 35 +++
 rtl/prog_loader.sv | 137 +++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_if
//  Description : Host byte stream / program RAM write port bundle for the
//                program loader. The master side is the host, the slave side
//                is the loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if;
    logic        load_req;
    logic [7:0]  word_count;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        prog_wr_en;
    logic [6:0]  prog_wr_addr;
    logic [15:0] prog_wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output load_req, word_count, byte_valid, byte_data,
        input  byte_ready, prog_wr_en, prog_wr_addr, prog_wr_data,
               start, busy, done, err
    );

    modport slave (
        input  load_req, word_count, byte_valid, byte_data,
        output byte_ready, prog_wr_en, prog_wr_addr, prog_wr_data,
               start, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Assembles a host byte stream (high byte first) into 16-bit
//                words, writes them to program RAM at consecutive addresses
//                and optionally issues a one-cycle start pulse at the end.
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int MAX_WORDS  = 128,
    parameter int AUTO_START = 1
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    prog_loader_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
        START = 3'd4
    } state_t;

    // Nine bits so that a depth of exactly 128 compares against 8-bit counts
    localparam logic [8:0] c_max_words = 9'(MAX_WORDS);

    state_t     r_state;
    logic [7:0] r_count;
    logic [7:0] r_index;   // one bit wider than the address so 128 never wraps
    logic [7:0] r_hi;
    logic [7:0] r_lo;
    logic       r_byte_ready;
    logic       r_wr_en;
    logic       r_start;
    logic       r_busy;
    logic       r_done;
    logic       r_err;

    logic w_count_ok;
    logic w_accept;
    logic w_last;

    assign w_count_ok = (bus.word_count != 8'd0) &&
                        ({1'b0, bus.word_count} <= c_max_words);
    assign w_accept   = bus.byte_valid && r_byte_ready;
    assign w_last     = (r_index == (r_count - 8'd1));

    // Address and data are held in the index and byte registers; they are
    // only meaningful while prog_wr_en is high.
    assign bus.byte_ready   = r_byte_ready;
    assign bus.prog_wr_en   = r_wr_en;
    assign bus.prog_wr_addr = r_index[6:0];
    assign bus.prog_wr_data = {r_hi, r_lo};
    assign bus.start        = r_start;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;

    // Load-session FSM; every output is a register updated with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_count      <= 8'd0;
            r_index      <= 8'd0;
            r_hi         <= 8'd0;
            r_lo         <= 8'd0;
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.load_req) begin
                        r_done <= 1'b0;
                        if (w_count_ok) begin
                            r_count      <= bus.word_count;
                            r_index      <= 8'd0;
                            r_err        <= 1'b0;
                            r_state      <= HI;
                            r_byte_ready <= 1'b1;
                            r_busy       <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                HI: begin
                    if (w_accept) begin
                        r_hi    <= bus.byte_data;
                        r_state <= LO;
                    end
                end
                LO: begin
                    if (w_accept) begin
                        r_lo         <= bus.byte_data;
                        r_state      <= WRITE;
                        r_byte_ready <= 1'b0;
                        r_wr_en      <= 1'b1;
                    end
                end
                WRITE: begin
                    r_index <= r_index + 8'd1;
                    if (!w_last) begin
                        r_state      <= HI;
                        r_byte_ready <= 1'b1;
                    end else if (AUTO_START != 0) begin
                        r_state <= START;
                        r_start <= 1'b1;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                START: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state      <= IDLE;
                    r_byte_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
